// File: rtl/io_bcd_pkg.sv
// Shared types, constants and helpers for the binary-to-BCD display converter.
// Segment helpers are used only when IO_BCD_SEG7_EN is defined.
package io_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic int unsigned pow10(
    input int unsigned n
  );
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/io_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Define IO_BCD_SEG7_EN to add registered active-low 7-segment outputs.
module io_bcd_converter
  import io_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
`ifdef IO_BCD_SEG7_EN
  output logic                  busy,
  output logic [7*DIGITS-1:0]   seg_out
`else
  output logic                  busy
`endif
);

  localparam int          SW    = 4*DIGITS + 4;
  localparam int          CW    = $clog2(BIN_W + 1);
  localparam int unsigned LIMIT = pow10(DIGITS);

  state_e                state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [SW-1:0]         scr_q, scr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovp_q, ovp_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;

  logic [SW-1:0]         scr_adj;
  logic [SW-1:0]         scr_sh;

  // One extra guard nibble absorbs carries from out-of-range values
  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (scr_q[4*g +: 4]),
      .nib_o (scr_adj[4*g +: 4])
    );
  end

  assign scr_sh = {scr_adj[SW-2:0], bin_q[BIN_W-1]};

`ifdef IO_BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [7*DIGITS-1:0] seg_nxt;

  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_nxt[7*i +: 7] = ovp_q ? SEG_DASH
                                : seg7(scr_sh[4*i +: 4]);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    ovp_d     = ovp_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
`ifdef IO_BCD_SEG7_EN
    seg_d     = seg_q;
`endif
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(BIN_W);
          ovp_d   = 32'(bin_in) >= LIMIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        scr_d = scr_sh;
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = ovp_q ? {DIGITS{4'h9}}
                          : scr_sh[4*DIGITS-1:0];
          ovf_d   = ovp_q;
`ifdef IO_BCD_SEG7_EN
          seg_d   = seg_nxt;
`endif
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovp_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef IO_BCD_SEG7_EN
      seg_q   <= {DIGITS{SEG_BLANK}};
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovp_q   <= ovp_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef IO_BCD_SEG7_EN
      seg_q   <= seg_d;
`endif
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
`ifdef IO_BCD_SEG7_EN
  assign seg_out  = seg_q;
`endif

endmodule

// File: tb/tb_io_bcd_converter.sv
// Directed bench for io_bcd_converter at (8,3), (6,2) and (8,2).
// Segment outputs are checked when IO_BCD_SEG7_EN is defined.
module tb_io_bcd_converter;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] bin;

  logic        rdyA, ovA, ofA, bsA;
  logic [11:0] bcdA;
  logic        rdyB, ovB, ofB, bsB;
  logic [7:0]  bcdB;
  logic        rdyC, ovC, ofC, bsC;
  logic [7:0]  bcdC;
`ifdef IO_BCD_SEG7_EN
  logic [20:0] segA;
  logic [13:0] segB, segC;
`endif

  always #5 clock = ~clock;

  io_bcd_converter #(.BIN_W(8), .DIGITS(3)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_ready(rdyA), .bin_in(bin), .out_valid(ovA),
    .bcd_out(bcdA), .overflow(ofA),
`ifdef IO_BCD_SEG7_EN
    .seg_out(segA),
`endif
    .busy(bsA)
  );

  io_bcd_converter #(.BIN_W(6), .DIGITS(2)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_ready(rdyB), .bin_in(bin[5:0]), .out_valid(ovB),
    .bcd_out(bcdB), .overflow(ofB),
`ifdef IO_BCD_SEG7_EN
    .seg_out(segB),
`endif
    .busy(bsB)
  );

  io_bcd_converter #(.BIN_W(8), .DIGITS(2)) u_c (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_ready(rdyC), .bin_in(bin), .out_valid(ovC),
    .bcd_out(bcdC), .overflow(ofC),
`ifdef IO_BCD_SEG7_EN
    .seg_out(segC),
`endif
    .busy(bsC)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] ea;
    logic        ofa;
    logic [7:0]  eb;
    logic [7:0]  ec;
    logic        ofc;
  } vec_t;

  vec_t        tbl[12];
  int          checks = 0;
  int          failures = 0;
  logic [11:0] prevA;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef IO_BCD_SEG7_EN
  function automatic logic [6:0] sg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] eseg(input logic [11:0] b,
                                       input int nd, input logic of);
    logic [20:0] r;
    r = '0;
    for (int i = 0; i < nd; i++)
      r[7*i +: 7] = of ? 7'b0111111 : sg(b[4*i +: 4]);
    return r;
  endfunction
`endif

  task automatic wait_idle();
    int n = 0;
    while (!(rdyA && rdyB && rdyC) && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_before", 32'(rdyA && rdyB && rdyC), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int pa = 0, pb = 0, pc = 0, la = 0, lb = 0, lc = 0;
    logic [11:0] ca = '0;
    logic [7:0] cb = '0, cc = '0;
    logic oa = 0, ob = 0, oc = 0, bad = 0;
`ifdef IO_BCD_SEG7_EN
    logic [20:0] sa = '0;
    logic [13:0] sb = '0, sc = '0;
`endif
    wait_idle();
    in_valid = 1'b1;
    bin = v.bin;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      if (k == 2) bin = 8'd7;
      if (k == 3) chk("hold_a", 32'(bcdA), 32'(prevA));
      if (k <= 8 && !(bsA && !rdyA)) bad = 1;
      if (ovA) begin
        pa++; la = k; ca = bcdA; oa = ofA;
`ifdef IO_BCD_SEG7_EN
        sa = segA;
`endif
      end
      if (ovB) begin
        pb++; lb = k; cb = bcdB; ob = ofB;
`ifdef IO_BCD_SEG7_EN
        sb = segB;
`endif
      end
      if (ovC) begin
        pc++; lc = k; cc = bcdC; oc = ofC;
`ifdef IO_BCD_SEG7_EN
        sc = segC;
`endif
      end
    end
    chk($sformatf("busy_a[%0d]", v.bin), 32'(bad), 32'd0);
    chk($sformatf("pulses_a[%0d]", v.bin), 32'(pa), 32'd1);
    chk($sformatf("lat_a[%0d]", v.bin), 32'(la), 32'd8);
    chk($sformatf("bcd_a[%0d]", v.bin), 32'(ca), 32'(v.ea));
    chk($sformatf("ovf_a[%0d]", v.bin), 32'(oa), 32'(v.ofa));
    chk($sformatf("pulses_b[%0d]", v.bin), 32'(pb), 32'd1);
    chk($sformatf("lat_b[%0d]", v.bin), 32'(lb), 32'd6);
    chk($sformatf("bcd_b[%0d]", v.bin), 32'(cb), 32'(v.eb));
    chk($sformatf("ovf_b[%0d]", v.bin), 32'(ob), 32'd0);
    chk($sformatf("pulses_c[%0d]", v.bin), 32'(pc), 32'd1);
    chk($sformatf("lat_c[%0d]", v.bin), 32'(lc), 32'd8);
    chk($sformatf("bcd_c[%0d]", v.bin), 32'(cc), 32'(v.ec));
    chk($sformatf("ovf_c[%0d]", v.bin), 32'(oc), 32'(v.ofc));
`ifdef IO_BCD_SEG7_EN
    chk("seg_a", 32'(sa), 32'(eseg(v.ea, 3, v.ofa)));
    chk("seg_b", 32'(sb), 32'(eseg({4'h0, v.eb}, 2, 1'b0)));
    chk("seg_c", 32'(sc), 32'(eseg({4'h0, v.ec}, 2, v.ofc)));
`endif
    prevA = v.ea;
  endtask

  initial begin
    int nacc, npul, acc1, acc2, t1, t2;
    logic acc, seen;
    logic [11:0] v1, v2;

    tbl[0]  = '{8'd0,   12'h000, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'd255, 12'h255, 1'b0, 8'h63, 8'h99, 1'b1};
    tbl[2]  = '{8'd59,  12'h059, 1'b0, 8'h59, 8'h59, 1'b0};
    tbl[3]  = '{8'd100, 12'h100, 1'b0, 8'h36, 8'h99, 1'b1};
    tbl[4]  = '{8'd42,  12'h042, 1'b0, 8'h42, 8'h42, 1'b0};
    tbl[5]  = '{8'd99,  12'h099, 1'b0, 8'h35, 8'h99, 1'b0};
    tbl[6]  = '{8'd200, 12'h200, 1'b0, 8'h08, 8'h99, 1'b1};
    tbl[7]  = '{8'd9,   12'h009, 1'b0, 8'h09, 8'h09, 1'b0};
    tbl[8]  = '{8'd10,  12'h010, 1'b0, 8'h10, 8'h10, 1'b0};
    tbl[9]  = '{8'd63,  12'h063, 1'b0, 8'h63, 8'h63, 1'b0};
    tbl[10] = '{8'd64,  12'h064, 1'b0, 8'h00, 8'h64, 1'b0};
    tbl[11] = '{8'd123, 12'h123, 1'b0, 8'h59, 8'h99, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0;
    bin = '0;
    prevA = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(rdyA), 32'd1);
    chk("rst_valid", 32'(ovA), 32'd0);
    chk("rst_bcd", 32'(bcdA), 32'd0);
    chk("rst_ovf", 32'(ofA), 32'd0);
    chk("rst_busy", 32'(bsA), 32'd0);
`ifdef IO_BCD_SEG7_EN
    chk("rst_seg", 32'(segA), 32'h1FFFFF);
`endif
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // in_valid held high: second value waits for the IDLE after DONE
    wait_idle();
    nacc = 0; npul = 0; acc1 = 0; acc2 = 0; t1 = 0; t2 = 0;
    v1 = '0; v2 = '0;
    in_valid = 1'b1;
    bin = 8'd17;
    for (int t = 1; t <= 40; t++) begin
      acc = in_valid && rdyA;
      @(posedge clock); #1;
      if (acc) begin
        nacc++;
        if (nacc == 1) begin acc1 = t; bin = 8'd38; end
        if (nacc == 2) begin acc2 = t; in_valid = 1'b0; end
      end
      if (ovA) begin
        npul++;
        if (npul == 1) begin t1 = t; v1 = bcdA; end
        if (npul == 2) begin t2 = t; v2 = bcdA; end
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_pulses", 32'(npul), 32'd2);
    chk("b2b_first", 32'(v1), 32'h017);
    chk("b2b_second", 32'(v2), 32'h038);
    chk("b2b_acc_gap", 32'(acc2 - acc1), 32'd10);
    chk("b2b_out_gap", 32'(t2 - t1), 32'd10);
    prevA = 12'h038;

    // Reset four cycles into a conversion
    wait_idle();
    in_valid = 1'b1;
    bin = 8'd200;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_busy", 32'(bsA), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mrst_busy", 32'(bsA), 32'd0);
    chk("mrst_ready", 32'(rdyA), 32'd1);
    chk("mrst_bcd", 32'(bcdA), 32'd0);
    chk("mrst_ovf", 32'(ofA), 32'd0);
    chk("mrst_valid", 32'(ovA), 32'd0);
`ifdef IO_BCD_SEG7_EN
    chk("mrst_seg", 32'(segA), 32'h1FFFFF);
`endif
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (ovA || ovB || ovC) seen = 1'b1;
    end
    chk("mrst_no_pulse", 32'(seen), 32'd0);
    prevA = '0;
    run_vec(tbl[11]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bcd_converter.md
Name: io_bcd_converter

Overview:
Sequential binary-to-BCD converter on the display path of the single-cycle computer. It consumes the binary values the CPU writes to the memory-mapped result port, plus the raw switch operands. It produces packed BCD digits for the active-low 7-segment digit decoders. The conversion is an iterative double-dabble (shift-add-3) that handles one input bit per clock, so wide values need no combinational divide/modulo.

Parameters:
BIN_W, 8, width of the binary input; legal range 4..20.
DIGITS, 3, number of BCD output digits; legal range 1..6.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  bin_in is valid this cycle.
in_ready  output  1  converter can accept a value this cycle.
bin_in  input  BIN_W  unsigned binary value to convert.
out_valid  output  1  one-cycle pulse: bcd_out/overflow were updated at the preceding edge.
bcd_out  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
overflow  output  1  last converted value was >= 10^DIGITS.
busy  output  1  conversion in progress (state != IDLE).

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values: in_ready=1, out_valid=0, bcd_out=0, overflow=0, busy=0, bit counter=0, shift registers=0.
- Reset mid-conversion: the next edge is IDLE with all reset values, and the partial result is discarded.
- IDLE: in_ready=1. When in_valid=1, the edge performs these actions and moves to SHIFT:
  - load the binary shift register with bin_in;
  - clear the BCD scratch register;
  - set counter=BIN_W;
  - latch ovf_pending = (bin_in >= 10^DIGITS), with the constant computed at elaboration.
- SHIFT: in_ready=0 and busy=1. Each edge does the following in a single cycle:
  - every scratch nibble >= 5 gets +3;
  - {scratch, binary} shifts left by 1;
  - counter decrements.
  The edge where counter goes 1->0 moves to DONE.
- Scratch register width is 4*DIGITS+4 bits (one guard nibble), so overflowing values do not corrupt the low digits. The guard nibble is discarded at output.
- DONE entry edge (the last SHIFT edge) registers the following:
  - bcd_out = scratch low digits, or all 4'h9 if ovf_pending (saturate);
  - overflow = ovf_pending.
  In DONE, out_valid=1 for exactly this one cycle, with in_ready=0 and busy=1. The next edge returns to IDLE.
- Latency: accept edge, then BIN_W shift edges, then out_valid high in the following cycle. That is BIN_W+1 cycles from accept to out_valid; default 9. Throughput is one conversion per BIN_W+2 cycles.
- in_valid while in_ready=0 is ignored (no queueing). Upstream holds or re-presents the value.
- bcd_out and overflow hold their value until the next DONE entry. They are unchanged by new accepts.
- bin_in is sampled only at the accept edge; later changes have no effect.

Optional Feature:
IO_BCD_SEG7_EN:
- Defined: adds output seg_out [7*DIGITS], active-low segment codes {g,f,e,d,c,b,a} registered alongside bcd_out.
  - Digit codes: 0=1000000, 1=1111001, ..., 9=0010000.
  - Reset value is all 1111111 (blank).
  - When overflow=1, every digit shows 0111111 (dash).
- Undefined: seg_out port and its logic are absent; everything else is identical.

Decomposition:
- Package io_bcd_pkg holds the state enum (IDLE/SHIFT/DONE), a function returning 10^n, and the SEG_BLANK/SEG_DASH constants.
- Sub-module bcd_digit_adj: one nibble, combinational "add 3 if >= 5". It is instantiated DIGITS+1 times in a generate loop.
- The 7-segment lookup under IO_BCD_SEG7_EN is a package function, not a module.

Test Plan:
- Default params, reset, then in_valid with bin_in=0 -> out_valid pulses in cycle 9 after accept; bcd_out=12'h000, overflow=0; with the macro, all digits 1000000.
- bin_in=255 -> bcd_out=12'h255 after 9 cycles; busy=1 and in_ready=0 throughout; bin_in changed to 7 mid-conversion has no effect.
- BIN_W=6, DIGITS=2, bin_in=59 -> bcd_out=8'h59 after 7 cycles, out_valid high exactly 1 cycle.
- BIN_W=8, DIGITS=2, bin_in=100 -> bcd_out=8'h99, overflow=1; with the macro, seg_out is two dashes. A following bin_in=42 -> 8'h42, overflow=0.
- in_valid held high continuously with values 17 then 38 -> the second value is accepted only in the IDLE cycle after DONE; outputs 12'h017 then 12'h038, spaced 10 cycles apart.
- reset asserted 4 cycles into a conversion of 200 -> the next cycle is IDLE with bcd_out=0, out_valid never pulses; a new accept of 123 yields 12'h123.
